// File: rtl/two_four_pkg.sv
// Shared types and helpers for the 2:4 pulse decoder.
package two_four_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] W_IDLE = 4'b0000;

    // 2-bit code to one-hot select line
    function automatic logic [3:0] decode_onehot(input logic [1:0] code);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[code] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/two_four_pulse_decoder_hold_counter.sv
// Loadable down-counter timing the length of a decoded pulse.
// Saturates at zero so a stale decrement can never wrap around.
module hold_counter #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              dec,
    output logic              last
);

    localparam logic [HOLD_W-1:0] ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    logic [HOLD_W-1:0] count;

    // load has priority over decrement; hold at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign last = (count == ONE);

endmodule

// File: rtl/two_four_pulse_decoder.sv
// Registered 2:4 decoder emitting a timed one-hot pulse with a
// break-before-make gap, plus an optional auto-scan of all four lines.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | W = 0000, ready for a code or a scan step
// ST_DRIVE | W = one-hot of latched code, counter running down
// ST_GAP   | W = 0000, done pulse, scan index advances if scanning
module two_four_pulse_decoder
    import two_four_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        Y,
    input  logic [HOLD_W-1:0] hold,
    input  logic              scan,
    output logic [3:0]        W,
    output logic              zero,
    output logic              done
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [1:0]        code_q;
    logic [1:0]        scan_idx;
    logic              from_scan;
    logic [HOLD_W-1:0] hold_eff;
    logic              accept;
    logic              scan_start;
    logic              start;
    logic [1:0]        start_code;
    logic              ctr_dec;
    logic              ctr_last;

    // a zero hold still produces a one-cycle pulse
    assign hold_eff   = (hold == '0) ? HOLD_ONE : hold;

    assign in_ready   = en && !rst && (state_q == ST_IDLE);
    assign accept     = in_valid && in_ready;
    // an offered code always wins over the scan sequencer
    assign scan_start = (state_q == ST_IDLE) && !accept && scan && en && !rst;
    assign start      = accept || scan_start;
    assign start_code = accept ? Y : scan_idx;
    assign ctr_dec    = en && (state_q == ST_DRIVE);

    hold_counter #(
        .HOLD_W (HOLD_W)
    ) u_hold_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (hold_eff),
        .dec      (ctr_dec),
        .last     (ctr_last)
    );

    // sequencing FSM with registered W / zero / done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= 2'b00;
            scan_idx  <= 2'b00;
            from_scan <= 1'b0;
            W         <= W_IDLE;
            zero      <= 1'b1;
            done      <= 1'b0;
        end else if (!en) begin
            // abort: drop the line at once, no done, scan position kept
            state_q <= ST_IDLE;
            W       <= W_IDLE;
            zero    <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q   <= ST_DRIVE;
                        code_q    <= start_code;
                        from_scan <= scan_start;
                        W         <= decode_onehot(start_code);
                        zero      <= 1'b0;
                    end else begin
                        W    <= W_IDLE;
                        zero <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (ctr_last) begin
                        state_q <= ST_GAP;
                        W       <= W_IDLE;
                        zero    <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        W    <= decode_onehot(code_q);
                        zero <= 1'b0;
                        done <= 1'b0;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                    W       <= W_IDLE;
                    zero    <= 1'b1;
                    done    <= 1'b0;
                    if (from_scan) begin
                        scan_idx <= scan_idx + 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    W       <= W_IDLE;
                    zero    <= 1'b1;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_two_four_pulse_decoder.sv
// Randomised and directed bench for two_four_pulse_decoder against a
// timeline model: each started pulse is recorded as absolute cycle numbers.
module tb_two_four_pulse_decoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] Y;
    logic [7:0] hold;
    logic       scan;
    logic [3:0] W;
    logic       zero;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    two_four_pulse_decoder #(
        .HOLD_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Y        (Y),
        .hold     (hold),
        .scan     (scan),
        .W        (W),
        .zero     (zero),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int cyc    = 0;
    int d_first = -1;
    int d_last  = -1;
    int gap_at  = -1;
    int m_code  = 0;
    int m_sidx  = 0;
    bit m_sf    = 1'b0;
    bit armed   = 1'b0;

    task automatic m_clear();
        d_first = -1;
        d_last  = -1;
        gap_at  = -1;
    endtask

    task automatic m_start(input int code, input bit from_scan);
        int n;
        n = (hold == 0) ? 1 : int'(hold);
        d_first = cyc + 1;
        d_last  = cyc + n;
        gap_at  = cyc + n + 1;
        m_code  = code;
        m_sf    = from_scan;
    endtask

    task automatic model_step();
        if (rst) begin
            m_clear();
            m_sidx = 0;
            armed  = 1'b1;
        end else if (!en) begin
            m_clear();
        end else if (cyc > gap_at) begin
            if (in_valid)  m_start(int'(Y), 1'b0);
            else if (scan) m_start(m_sidx, 1'b1);
        end else if (cyc == gap_at && m_sf) begin
            m_sidx = (m_sidx + 1) % 4;
        end
        cyc++;
    endtask

    task automatic check_all();
        logic [3:0] exp_w;
        exp_w = 4'b0000;
        if (d_first >= 0 && cyc >= d_first && cyc <= d_last) exp_w = 4'(1 << m_code);
        check("W",        32'(W),        32'(exp_w));
        check("zero",     32'(zero),     32'(exp_w == 4'b0000));
        check("done",     32'(done),     32'(cyc == gap_at));
        check("in_ready", 32'(in_ready), 32'(en && !rst && (cyc > gap_at)));
        check("onehot",   32'($countones(W) <= 1), 32'd1);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (armed) check_all();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin : stim
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; Y = 2'b00; hold = 8'd0; scan = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(3);

        // single code 10, hold 3
        Y = 2'b10; hold = 8'd3; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sc_W_drive", 32'(W), 32'h4);
        end
        @(negedge clk);
        check("sc_W_gap", 32'(W), 32'h0);
        check("sc_done", 32'(done), 32'h1);
        @(negedge clk);
        check("sc_ready", 32'(in_ready), 32'h1);
        tick(2);

        // hold zero then back-to-back code held valid
        Y = 2'b11; hold = 8'd0; in_valid = 1'b1;
        tick(1);
        Y = 2'b00;
        tick(8);
        in_valid = 1'b0;
        tick(4);

        // scan through all lines and wrap
        scan = 1'b1; hold = 8'd2;
        tick(22);
        // offered code overrides scan
        in_valid = 1'b1; Y = 2'b01;
        tick(6);
        in_valid = 1'b0;
        tick(6);
        scan = 1'b0;
        tick(6);

        // abort in 4th drive cycle
        Y = 2'b01; hold = 8'd10; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(3);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        tick(4);

        // reset mid-pulse, then scan restarts at W[0]
        Y = 2'b11; hold = 8'd8; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; scan = 1'b1; hold = 8'd1;
        tick(12);
        scan = 1'b0;
        tick(6);

        // maximum hold must not wrap
        Y = 2'b10; hold = 8'd255; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(262);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 19) != 0);
            in_valid = ($urandom_range(0, 2) == 0);
            Y        = 2'($urandom);
            hold     = 8'($urandom_range(0, 6));
            scan     = ($urandom_range(0, 3) == 0);
            tick(1);
        end
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; scan = 1'b0;
        tick(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/two_four_pulse_decoder.md
# two_four_pulse_decoder

Registered 2:4 decoder that turns a 2-bit code into a timed one-hot pulse on four select lines, the inverse of the team's 4:2 encoder. Accepts codes via a valid/ready handshake, drives the decoded line for a programmable number of cycles, then inserts a one-cycle break-before-make gap. An optional scan mode cycles all four lines automatically. It sits between control logic and one-hot-selected loads such as LED or digit enables.

## Interface
- `HOLD_W`, default 8: width of the hold-count input and internal counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  block enable; low aborts any activity and blocks acceptance.
- `in_valid`  in  1  a code is presented on `Y`.
- `in_ready`  out  1  block can accept a code this cycle.
- `Y`  in  2  code to decode: 00→W[0], 01→W[1], 10→W[2], 11→W[3].
- `hold`  in  HOLD_W  pulse length in cycles, sampled at acceptance; 0 is treated as 1.
- `scan`  in  1  auto-cycle W[0]..W[3] while idle and no code is offered.
- `W`  out  4  registered one-hot output, or 0000.
- `zero`  out  1  registered; high exactly when `W == 4'b0000`.
- `done`  out  1  registered one-cycle pulse in the gap cycle after every completed pulse.

## Operation
- States: IDLE, DRIVE, GAP.
- IDLE: `W = 0000`.
  - On `in_valid && in_ready`: latch `Y`, load the counter with `max(hold,1)`, go to DRIVE.
  - Otherwise, if `scan && en`: latch `scan_idx`, load `max(hold,1)`, go to DRIVE.
  - `in_valid` has priority over `scan` in the same cycle.
- DRIVE: `W` = one-hot of the latched code. The counter decrements each cycle. When the counter is 1, go to GAP.
- GAP: `W = 0000`, `done = 1` for this cycle only, then go to IDLE. If the pulse came from scan, `scan_idx` increments mod 4 (11 wraps to 00).
- `in_ready = en && !rst && state == IDLE` (combinational from registered state).
- `en` low in any state: next state is IDLE, `W` goes to 0 next cycle, no `done`, `scan_idx` unchanged, counter value ignored.
- `hold` and `Y` are sampled only at acceptance. Later changes do not affect a pulse in progress.
- `W` is never multi-hot. It is never nonzero on two consecutive different codes without a 0000 cycle between them.
- Reset values: state IDLE, `W = 0000`, `zero = 1`, `done = 0`, `scan_idx = 00`, counter 0. `in_ready = 0` while `rst` is high.

## Timing
- Code accepted at edge k → `W` one-hot from cycle k+1 through k+N, where `N = max(hold,1)`.
- Gap (`W = 0`, `done = 1`) in cycle k+N+1.
- `in_ready` high again in cycle k+N+2.
- Throughput is one pulse per N+2 cycles, including the IDLE cycle.
- Scan start is the same as acceptance, with the edge at the IDLE cycle where `scan` is sampled high.
- `hold = 2^HOLD_W−1` is legal; the counter must not overflow or wrap.
- `rst` mid-pulse: `W = 0000` and `zero = 1` in the cycle after the reset edge, with no `done`.
- `en` deasserted on the same edge that would accept a code: the code is not accepted, because `in_ready` was already low.

## Structure
- Shared package `two_four_pkg` contains:
  - state enum (IDLE, DRIVE, GAP);
  - the code-to-one-hot decode function;
  - the constant `W_IDLE = 4'b0000`.
- Sub-module `hold_counter`: loadable HOLD_W-bit down-counter with a `load` input, a load value, and a `last` output (count == 1). Zero-to-one clamping is done in the parent.
- Everything else stays in one module: state register, code latch, `scan_idx`, and output registers.

## Test plan
- Reset and idle: hold `rst` 3 cycles, then release with no stimulus → `W = 0000`, `zero = 1`, `done = 0`, `in_ready = 1` on the first cycle after release.
- Single code: `Y = 10`, `hold = 3`, accepted at cycle 5 → `W = 0100` in cycles 6–8, `W = 0000` and `done = 1` in cycle 9, `in_ready = 1` in cycle 10.
- Hold zero and back-to-back: `Y = 11` with `hold = 0`, then `Y = 00` held valid → `W = 1000` for 1 cycle, 1 gap cycle, then `W = 0001`; `W` is never multi-hot.
- Scan: `scan = 1`, `hold = 2`, no `in_valid` → `W` sequence 0001,0001,0,(idle),0010,0010,0,(idle),0100,…,1000, then wraps to 0001. Asserting `in_valid` with `Y = 01` during an idle cycle takes priority over the scan.
- Abort: `Y = 01`, `hold = 10`, `en` dropped in the 4th DRIVE cycle → `W = 0000` next cycle, no `done`, `in_ready` stays low until `en` is high again.
- Mid-pulse reset: `rst` during DRIVE with `Y = 11` → `W = 0000`, `zero = 1` the next cycle; a scan after reset restarts at W[0].
